// File: rtl/cpuif_arb_pkg.sv
// cpuif_arb_pkg: shared types and defaults for the two-requester
// register-bus arbiter (states, requester index, parameter defaults).
package cpuif_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 3;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_M0 = 1'b0;
  localparam req_idx_t REQ_M1 = 1'b1;

endpackage

// File: rtl/cpuif_bus_arbiter_if.sv
// cpuif_bus_arbiter_if: requester-side and register-block-side signals.
// master = arbiter view, slave = requesters plus register block.
interface cpuif_bus_arbiter_if #(
  parameter int ADDR_WIDTH = cpuif_arb_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = cpuif_arb_pkg::DEF_DATA_WIDTH
);

  logic                  m0_req;
  logic                  m0_req_is_wr;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wr_data;
  logic [DATA_WIDTH-1:0] m0_wr_biten;
  logic                  m0_ack;
  logic [DATA_WIDTH-1:0] m0_rd_data;
  logic                  m0_err;

  logic                  m1_req;
  logic                  m1_req_is_wr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wr_data;
  logic [DATA_WIDTH-1:0] m1_wr_biten;
  logic                  m1_ack;
  logic [DATA_WIDTH-1:0] m1_rd_data;
  logic                  m1_err;

  logic                  o_bus_req;
  logic                  o_bus_req_is_wr;
  logic [ADDR_WIDTH-1:0] o_bus_addr;
  logic [DATA_WIDTH-1:0] o_bus_wr_data;
  logic [DATA_WIDTH-1:0] o_bus_wr_biten;
  logic                  bus_ready;
  logic [DATA_WIDTH-1:0] bus_rd_data;
  logic                  bus_err;
  logic                  bus_req_stall_wr;
  logic                  bus_req_stall_rd;

  modport master (
    input  m0_req, m0_req_is_wr, m0_addr,
    input  m0_wr_data, m0_wr_biten,
    output m0_ack, m0_rd_data, m0_err,
    input  m1_req, m1_req_is_wr, m1_addr,
    input  m1_wr_data, m1_wr_biten,
    output m1_ack, m1_rd_data, m1_err,
    output o_bus_req, o_bus_req_is_wr, o_bus_addr,
    output o_bus_wr_data, o_bus_wr_biten,
    input  bus_ready, bus_rd_data, bus_err,
    input  bus_req_stall_wr, bus_req_stall_rd
  );

  modport slave (
    output m0_req, m0_req_is_wr, m0_addr,
    output m0_wr_data, m0_wr_biten,
    input  m0_ack, m0_rd_data, m0_err,
    output m1_req, m1_req_is_wr, m1_addr,
    output m1_wr_data, m1_wr_biten,
    input  m1_ack, m1_rd_data, m1_err,
    input  o_bus_req, o_bus_req_is_wr, o_bus_addr,
    input  o_bus_wr_data, o_bus_wr_biten,
    output bus_ready, bus_rd_data, bus_err,
    output bus_req_stall_wr, bus_req_stall_rd
  );

endinterface

// File: rtl/cpuif_arb_rr2.sv
// cpuif_arb_rr2: two-way round-robin pick with last-grant memory.
// Last grant resets to requester 1 so requester 0 wins the first tie.
module cpuif_arb_rr2
  import cpuif_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic [1:0] req_i,
  input  logic     upd_i,
  input  req_idx_t upd_idx_i,
  output logic     gnt_vld_o,
  output req_idx_t gnt_idx_o
);

  req_idx_t last_q, last_d;

  // Pick the requester; on a tie favour the one not granted last.
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = REQ_M0;
    unique case (1'b1)
      (req_i == 2'b11): gnt_idx_o = ~last_q;
      (req_i == 2'b10): gnt_idx_o = REQ_M1;
      default:          gnt_idx_o = REQ_M0;
    endcase
  end

  // Last-grant moves only when an access completes.
  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = upd_idx_i;
  end

  // Last-grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_M1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/cpuif_bus_arbiter.sv
// cpuif_bus_arbiter: 2:1 register-bus arbiter, IDLE/ISSUE/WAIT FSM.
// Optional WAIT timeout: define CPUIF_ARB_TIMEOUT_EN.
module cpuif_bus_arbiter
  import cpuif_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic clk,
  input logic rst_n,
  cpuif_bus_arbiter_if.master bus
);

  arb_state_e state_q, state_d;
  req_idx_t   gnt_q, gnt_d;
  logic       wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] bite_q, bite_d;

  logic     rr_vld;
  req_idx_t rr_idx;
  logic     stall;
  logic     breq;
  logic     done;
  logic     tmo_hit;
  logic     act;
  logic     ack0, ack1;

  cpuif_arb_rr2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({bus.m1_req, bus.m0_req}),
    .upd_i     (done),
    .upd_idx_i (gnt_q),
    .gnt_vld_o (rr_vld),
    .gnt_idx_o (rr_idx)
  );

`ifdef CPUIF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count WAIT cycles without bus_ready; fire on the last allowed one.
  always_comb begin
    tmo_hit = (state_q == ST_WAIT) && !bus.bus_ready &&
              (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d = '0;
    if (state_q == ST_WAIT && !bus.bus_ready && !tmo_hit)
      cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next state, grant latch, strobe and completion.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    bite_d  = bite_q;
    breq    = 1'b0;
    done    = 1'b0;
    stall   = wr_q ? bus.bus_req_stall_wr
                   : bus.bus_req_stall_rd;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_vld) begin
          gnt_d   = rr_idx;
          state_d = ST_ISSUE;
          if (rr_idx == REQ_M1) begin
            wr_d   = bus.m1_req_is_wr;
            addr_d = bus.m1_addr;
            wdat_d = bus.m1_wr_data;
            bite_d = bus.m1_wr_biten;
          end else begin
            wr_d   = bus.m0_req_is_wr;
            addr_d = bus.m0_addr;
            wdat_d = bus.m0_wr_data;
            bite_d = bus.m0_wr_biten;
          end
        end
      end
      ST_ISSUE: begin
        if (!stall) begin
          breq = 1'b1;
          if (bus.bus_ready) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.bus_ready || tmo_hit) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= REQ_M0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      bite_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      bite_q  <= bite_d;
    end
  end

  // Bus side shows the latched access only while one is in flight.
  always_comb begin
    act                 = (state_q != ST_IDLE);
    bus.o_bus_req       = breq;
    bus.o_bus_req_is_wr = act & wr_q;
    bus.o_bus_addr      = act ? addr_q : '0;
    bus.o_bus_wr_data   = act ? wdat_q : '0;
    bus.o_bus_wr_biten  = act ? bite_q : '0;
  end

  // Route completion to the granted requester only.
  always_comb begin
    ack0 = done & (gnt_q == REQ_M0);
    ack1 = done & (gnt_q == REQ_M1);
    bus.m0_ack     = ack0;
    bus.m1_ack     = ack1;
    bus.m0_rd_data = (ack0 && !tmo_hit) ? bus.bus_rd_data : '0;
    bus.m1_rd_data = (ack1 && !tmo_hit) ? bus.bus_rd_data : '0;
    bus.m0_err     = ack0 & (tmo_hit | bus.bus_err);
    bus.m1_err     = ack1 & (tmo_hit | bus.bus_err);
  end

endmodule

// File: tb/tb_cpuif_bus_arbiter.sv
// tb_cpuif_bus_arbiter: vector table plus reset and WAIT-limit sequences.
// Inputs change #1 after posedge; outputs are compared at negedge.
module tb_cpuif_bus_arbiter;

  localparam logic [31:0] D0 = 32'hA5A5A5A5;
  localparam logic [31:0] B0 = 32'hFFFFFFFF;
  localparam logic [31:0] D1 = 32'h0F0F0F0F;
  localparam logic [31:0] B1 = 32'h0000FFFF;
  localparam int NV = 13;

  // ctl = {r0, r1, w0, w1, stall_wr, stall_rd, ready, err}
  // ebr = {o_bus_req, o_bus_req_is_wr}
  // eack = {m0_ack, m1_ack}, eerr = {m0_err, m1_err}
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] rdat;
    logic [1:0]  ebr;
    logic [2:0]  eaddr;
    logic [1:0]  eack;
    logic [31:0] erd0;
    logic [31:0] erd1;
    logic [1:0]  eerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tab [NV];

  cpuif_bus_arbiter_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bif ();

  cpuif_bus_arbiter #(
    .ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wd(input logic [2:0] a);
    case (a)
      3'd3:    return D0;
      3'd5:    return D1;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] a);
    case (a)
      3'd3:    return B0;
      3'd5:    return B1;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    bif.m0_req           = v.ctl[7];
    bif.m1_req           = v.ctl[6];
    bif.m0_req_is_wr     = v.ctl[5];
    bif.m1_req_is_wr     = v.ctl[4];
    bif.bus_req_stall_wr = v.ctl[3];
    bif.bus_req_stall_rd = v.ctl[2];
    bif.bus_ready        = v.ctl[1];
    bif.bus_err          = v.ctl[0];
    bif.bus_rd_data      = v.rdat;
  endtask

  task automatic check_row(input int i, input vec_t v);
    string p;
    p = $sformatf("row%0d", i);
    chk({p, ".breq"}, 32'(bif.o_bus_req), 32'(v.ebr[1]));
    chk({p, ".bwr"}, 32'(bif.o_bus_req_is_wr), 32'(v.ebr[0]));
    chk({p, ".addr"}, 32'(bif.o_bus_addr), 32'(v.eaddr));
    chk({p, ".wdat"}, bif.o_bus_wr_data, exp_wd(v.eaddr));
    chk({p, ".bite"}, bif.o_bus_wr_biten, exp_be(v.eaddr));
    chk({p, ".ack0"}, 32'(bif.m0_ack), 32'(v.eack[1]));
    chk({p, ".ack1"}, 32'(bif.m1_ack), 32'(v.eack[0]));
    chk({p, ".rd0"}, bif.m0_rd_data, v.erd0);
    chk({p, ".rd1"}, bif.m1_rd_data, v.erd1);
    chk({p, ".err0"}, 32'(bif.m0_err), 32'(v.eerr[1]));
    chk({p, ".err1"}, 32'(bif.m1_err), 32'(v.eerr[0]));
  endtask

  task automatic chk_idle_outs(input string p);
    chk({p, ".breq"}, 32'(bif.o_bus_req), 32'h0);
    chk({p, ".addr"}, 32'(bif.o_bus_addr), 32'h0);
    chk({p, ".bite"}, bif.o_bus_wr_biten, 32'h0);
    chk({p, ".ack0"}, 32'(bif.m0_ack), 32'h0);
    chk({p, ".ack1"}, 32'(bif.m1_ack), 32'h0);
    chk({p, ".err1"}, 32'(bif.m1_err), 32'h0);
  endtask

  initial begin
    int seen;
    int at;

    // tie after reset -> m0; stray ready in IDLE ignored; m0
    // re-requests at once -> tie again -> m1; m1 read stalled 3
    // cycles; then m0 write acked 2 cycles after strobe with
    // m0 dropping req while in WAIT.
    tab[0]  = '{8'b1100_0000, 32'h0, 2'b00, 3'd0, 2'b00,
                32'h0, 32'h0, 2'b00};
    tab[1]  = '{8'b1100_0010, 32'h12345678, 2'b10, 3'd3, 2'b10,
                32'h12345678, 32'h0, 2'b00};
    tab[2]  = '{8'b1110_0011, 32'hFFFFFFFF, 2'b00, 3'd0, 2'b00,
                32'h0, 32'h0, 2'b00};
    tab[3]  = '{8'b1110_0100, 32'h0, 2'b00, 3'd5, 2'b00,
                32'h0, 32'h0, 2'b00};
    tab[4]  = tab[3];
    tab[5]  = tab[3];
    tab[6]  = '{8'b1110_0000, 32'h0, 2'b10, 3'd5, 2'b00,
                32'h0, 32'h0, 2'b00};
    tab[7]  = '{8'b1110_0011, 32'h22222222, 2'b00, 3'd5, 2'b01,
                32'h0, 32'h22222222, 2'b01};
    tab[8]  = '{8'b1010_0000, 32'h0, 2'b00, 3'd0, 2'b00,
                32'h0, 32'h0, 2'b00};
    tab[9]  = '{8'b1010_0100, 32'h0, 2'b11, 3'd3, 2'b00,
                32'h0, 32'h0, 2'b00};
    tab[10] = '{8'b0000_0000, 32'h0, 2'b01, 3'd3, 2'b00,
                32'h0, 32'h0, 2'b00};
    tab[11] = '{8'b0000_0010, 32'h0, 2'b01, 3'd3, 2'b10,
                32'h0, 32'h0, 2'b00};
    tab[12] = '{8'b0000_0000, 32'h0, 2'b00, 3'd0, 2'b00,
                32'h0, 32'h0, 2'b00};

    bif.m0_addr     = 3'd3;
    bif.m0_wr_data  = D0;
    bif.m0_wr_biten = B0;
    bif.m1_addr     = 3'd5;
    bif.m1_wr_data  = D1;
    bif.m1_wr_biten = B1;
    drive(tab[12]);

    // reset state, with a request pending and ready high
    bif.m0_req    = 1'b1;
    bif.bus_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_outs("rst");
    @(posedge clk); #1;
    drive(tab[12]);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(tab[i]);
      @(negedge clk);
      check_row(i, tab[i]);
    end

    // reset while m1 read sits in WAIT
    @(posedge clk); #1;
    bif.m1_req = 1'b1;
    @(negedge clk);
    chk("wr.idle_breq", 32'(bif.o_bus_req), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr.issue_breq", 32'(bif.o_bus_req), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr.wait_addr", 32'(bif.o_bus_addr), 32'h5);
    #1;
    rst_n = 1'b0;
    bif.bus_ready = 1'b1;
    #1;
    chk_idle_outs("wr.in_rst");
    @(posedge clk); #1;
    chk("wr.rst_ack1", 32'(bif.m1_ack), 32'h0);
    rst_n = 1'b1;
    bif.m1_req = 1'b0;
    @(negedge clk);
    chk_idle_outs("wr.post");
    @(posedge clk); #1;
    bif.bus_ready = 1'b0;
    @(negedge clk);
    chk_idle_outs("wr.post2");

    // m0 read left in WAIT with no bus_ready
    @(posedge clk); #1;
    bif.m0_req = 1'b1;
    bif.m0_req_is_wr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("to.issue_breq", 32'(bif.o_bus_req), 32'h1);
    @(posedge clk); #1;
    bif.m0_req = 1'b0;
    bif.bus_rd_data = 32'hCAFEF00D;
    seen = 0;
    at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bif.m0_ack && seen == 0) begin
        seen = 1;
        at = k;
        chk("to.err0", 32'(bif.m0_err), 32'h1);
        chk("to.rd0", bif.m0_rd_data, 32'h0);
      end
      @(posedge clk); #1;
    end
`ifdef CPUIF_ARB_TIMEOUT_EN
    chk("to.ack_cycle", 32'(at), 32'd16);
`else
    chk("to.no_ack", 32'(seen), 32'h0);
`endif
    bif.bus_ready = 1'b1;
    @(negedge clk);
`ifdef CPUIF_ARB_TIMEOUT_EN
    chk("to.late_ready_ack0", 32'(bif.m0_ack), 32'h0);
    chk("to.late_ready_rd0", bif.m0_rd_data, 32'h0);
`else
    chk("to.late_ready_ack0", 32'(bif.m0_ack), 32'h1);
    chk("to.late_ready_rd0", bif.m0_rd_data, 32'hCAFEF00D);
`endif
    @(posedge clk); #1;
    bif.bus_ready = 1'b0;
    @(negedge clk);
    chk_idle_outs("to.end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
